mcb_port_responder: RTL and testbench

Synthesizable responder for one MIG Spartan-6 MCB user port (p0 signal set: command, write-data and read-data FIFOs), backed by on-chip block RAM instead of DDR2. It connects directly to the `ddr2_test` traffic engine in place of `memc3` for board bring-up without external memory and for fast simulation. It reproduces the MCB port's FIFO flags, counts and error reporting at cycle level.

---
 rtl/mcb_resp_pkg.sv | 40 ++++
 rtl/mcb_port_responder_if.sv | 44 ++++
 rtl/mcb_sync_fifo.sv | 56 +++++
 rtl/mcb_port_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_mcb_port_responder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcb_resp_pkg.sv
// Shared types for the block-RAM-backed MCB port responder: instruction codes,
// FSM states and FIFO entry layouts. MCB_RD_LATENCY_EN adds the read-latency state.
package mcb_resp_pkg;

    localparam int unsigned DataDepth = 64;
    localparam int unsigned CntWidth  = $clog2(DataDepth + 1);

    localparam logic [2:0] InstrWr   = 3'b000;
    localparam logic [2:0] InstrRd   = 3'b001;
    localparam logic [2:0] InstrWrAp = 3'b010;
    localparam logic [2:0] InstrRdAp = 3'b011;

`ifdef MCB_RD_LATENCY_EN
    typedef enum logic [1:0] {StIdle, StWrite, StRead, StRlat} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;
`endif

    // Command entry is padded to 41 bits; spare bits are always zero.
    typedef struct packed {
        logic [1:0]  spare;
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] byte_addr;
    } cmd_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } wr_t;

    function automatic logic is_write(logic [2:0] instr);
        return (instr == InstrWr) || (instr == InstrWrAp);
    endfunction

    function automatic logic is_read(logic [2:0] instr);
        return (instr == InstrRd) || (instr == InstrRdAp);
    endfunction

endpackage

// File: rtl/mcb_port_responder_if.sv
// MCB p0 user-port signal bundle; master is the traffic engine, slave the memory side.
interface mcb_port_responder_if;
    import mcb_resp_pkg::*;

    logic                calib_done;
    logic                p0_cmd_en;
    logic [2:0]          p0_cmd_instr;
    logic [5:0]          p0_cmd_bl;
    logic [29:0]         p0_cmd_byte_addr;
    logic                p0_cmd_empty;
    logic                p0_cmd_full;
    logic                p0_wr_en;
    logic [3:0]          p0_wr_mask;
    logic [31:0]         p0_wr_data;
    logic                p0_wr_full;
    logic                p0_wr_empty;
    logic [CntWidth-1:0] p0_wr_count;
    logic                p0_wr_underrun;
    logic                p0_wr_error;
    logic                p0_rd_en;
    logic [31:0]         p0_rd_data;
    logic                p0_rd_full;
    logic                p0_rd_empty;
    logic [CntWidth-1:0] p0_rd_count;
    logic                p0_rd_overflow;
    logic                p0_rd_error;

    modport master (
        input  calib_done, p0_cmd_empty, p0_cmd_full, p0_wr_full, p0_wr_empty, p0_wr_count,
               p0_wr_underrun, p0_wr_error, p0_rd_data, p0_rd_full, p0_rd_empty, p0_rd_count,
               p0_rd_overflow, p0_rd_error,
        output p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, p0_wr_en, p0_wr_mask,
               p0_wr_data, p0_rd_en
    );

    modport slave (
        output calib_done, p0_cmd_empty, p0_cmd_full, p0_wr_full, p0_wr_empty, p0_wr_count,
               p0_wr_underrun, p0_wr_error, p0_rd_data, p0_rd_full, p0_rd_empty, p0_rd_count,
               p0_rd_overflow, p0_rd_error,
        input  p0_cmd_en, p0_cmd_instr, p0_cmd_bl, p0_cmd_byte_addr, p0_wr_en, p0_wr_mask,
               p0_wr_data, p0_rd_en
    );

endinterface

// File: rtl/mcb_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered occupancy count.
module mcb_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    // At full a push is only taken when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= ptr_inc(wptr_q);
            if (do_pop)  rptr_q <= ptr_inc(rptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/mcb_port_responder.sv
// MCB p0 port responder backed by block RAM. Define MCB_RD_LATENCY_EN to insert
// RD_LATENCY idle cycles before each read burst.
module mcb_port_responder
    import mcb_resp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned CMD_DEPTH    = 4,
    parameter int unsigned DATA_DEPTH   = DataDepth,
    parameter int unsigned CALIB_CYCLES = 16,
    parameter int unsigned RD_LATENCY   = 8
) (
    input logic                 clk,
    input logic                 reset,
    mcb_port_responder_if.slave p0
);
    localparam int unsigned CalW = $clog2(CALIB_CYCLES + 1);

    cmd_t        cmd_in, cmd_head;
    wr_t         wr_in, wr_head;
    logic        cmd_empty, cmd_full, cmd_pop;
    logic        wr_empty, wr_full, wr_pop;
    logic        rd_empty, rd_full, rd_pop;
    logic [31:0] rd_head;
    logic [CntWidth-1:0] unused_cmd_count;
    logic        unused_cmd_bits;

    state_e      state_q, state_d;
    logic [6:0]  beat_q, beat_d;
    logic [5:0]  bl_q;
    logic [ADDR_WIDTH-1:0] base_q, ram_addr;
    logic        load, ram_we, ram_re, underrun_d, overflow_d;
    logic        rd_pend_q;
    logic [31:0] ram_rdata_q;
    logic [31:0] ram_q [2**ADDR_WIDTH];

    logic [CalW-1:0] cal_cnt_q;
    logic        calib_q;
    logic        underrun_q, overflow_q, wr_err_q, rd_err_q;

`ifdef MCB_RD_LATENCY_EN
    localparam int unsigned LatW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    logic [LatW-1:0] lat_q, lat_d;
`else
    logic [31:0] unused_rd_latency;
    assign unused_rd_latency = RD_LATENCY;
`endif

    assign cmd_in = '{spare: 2'b00, instr: p0.p0_cmd_instr, bl: p0.p0_cmd_bl,
                      byte_addr: p0.p0_cmd_byte_addr};
    assign wr_in  = '{mask: p0.p0_wr_mask, data: p0.p0_wr_data};
    assign unused_cmd_bits = ^{cmd_head.spare, cmd_head.byte_addr[1:0],
                               cmd_head.byte_addr[29:ADDR_WIDTH+2]};

    mcb_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH), .CNT_W(CntWidth)) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (p0.p0_cmd_en),
        .wdata (cmd_in),
        .pop   (cmd_pop),
        .rdata (cmd_head),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (unused_cmd_count)
    );

    mcb_sync_fifo #(.WIDTH($bits(wr_t)), .DEPTH(DATA_DEPTH), .CNT_W(CntWidth)) u_wr_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (p0.p0_wr_en),
        .wdata (wr_in),
        .pop   (wr_pop),
        .rdata (wr_head),
        .full  (wr_full),
        .empty (wr_empty),
        .count (p0.p0_wr_count)
    );

    mcb_sync_fifo #(.WIDTH(32), .DEPTH(DATA_DEPTH), .CNT_W(CntWidth)) u_rd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rd_pend_q),
        .wdata (ram_rdata_q),
        .pop   (rd_pop),
        .rdata (rd_head),
        .full  (rd_full),
        .empty (rd_empty),
        .count (p0.p0_rd_count)
    );

    assign rd_pop     = p0.p0_rd_en && !rd_empty;
    assign overflow_d = rd_pend_q && rd_full && !rd_pop;
    assign ram_addr   = base_q + ADDR_WIDTH'(beat_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            cal_cnt_q <= '0;
            calib_q   <= 1'b0;
        end else if (!calib_q) begin
            cal_cnt_q <= cal_cnt_q + 1'b1;
            if (cal_cnt_q == CalW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        cmd_pop    = 1'b0;
        load       = 1'b0;
        wr_pop     = 1'b0;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        underrun_d = 1'b0;
`ifdef MCB_RD_LATENCY_EN
        lat_d      = lat_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (calib_q && !cmd_empty) begin
                    cmd_pop = 1'b1;
                    load    = 1'b1;
                    beat_d  = '0;
                    if (is_write(cmd_head.instr)) begin
                        state_d = StWrite;
                    end else if (is_read(cmd_head.instr)) begin
`ifdef MCB_RD_LATENCY_EN
                        lat_d   = '0;
                        state_d = (RD_LATENCY == 0) ? StRead : StRlat;
`else
                        state_d = StRead;
`endif
                    end
                end
            end
            StWrite: begin
                // An empty write FIFO still consumes the beat.
                if (wr_empty) begin
                    underrun_d = 1'b1;
                end else begin
                    wr_pop = 1'b1;
                    ram_we = 1'b1;
                end
                beat_d = beat_q + 7'd1;
                if (beat_q == {1'b0, bl_q}) state_d = StIdle;
            end
            StRead: begin
                // One extra cycle after the last address lets the final word land.
                ram_re = (beat_q <= {1'b0, bl_q});
                beat_d = beat_q + 7'd1;
                if (beat_q == {1'b0, bl_q} + 7'd1) state_d = StIdle;
            end
`ifdef MCB_RD_LATENCY_EN
            StRlat: begin
                lat_d = lat_q + 1'b1;
                if (lat_q == LatW'(RD_LATENCY - 1)) state_d = StRead;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            bl_q      <= '0;
            base_q    <= '0;
            rd_pend_q <= 1'b0;
`ifdef MCB_RD_LATENCY_EN
            lat_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            rd_pend_q <= ram_re;
`ifdef MCB_RD_LATENCY_EN
            lat_q     <= lat_d;
`endif
            if (load) begin
                bl_q   <= cmd_head.bl;
                base_q <= cmd_head.byte_addr[ADDR_WIDTH+1:2];
            end
        end
    end

    // RAM contents survive reset; only the write strobe is gated.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (!wr_head.mask[b]) ram_q[ram_addr][8*b +: 8] <= wr_head.data[8*b +: 8];
            end
        end
        if (ram_re) ram_rdata_q <= ram_q[ram_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            wr_err_q   <= wr_err_q || underrun_d || (p0.p0_wr_en && wr_full && !wr_pop);
            rd_err_q   <= rd_err_q || overflow_d;
        end
    end

    assign p0.calib_done     = calib_q;
    assign p0.p0_cmd_empty   = cmd_empty;
    assign p0.p0_cmd_full    = cmd_full;
    assign p0.p0_wr_full     = wr_full;
    assign p0.p0_wr_empty    = wr_empty;
    assign p0.p0_wr_underrun = underrun_q;
    assign p0.p0_wr_error    = wr_err_q;
    assign p0.p0_rd_data     = rd_empty ? '0 : rd_head;
    assign p0.p0_rd_full     = rd_full;
    assign p0.p0_rd_empty    = rd_empty;
    assign p0.p0_rd_overflow = overflow_q;
    assign p0.p0_rd_error    = rd_err_q;

endmodule

// File: tb/tb_mcb_port_responder.sv
// Directed plus randomized bench for mcb_port_responder against a word-array memory model.
module tb_mcb_port_responder;
    import mcb_resp_pkg::*;

    localparam int unsigned AW = 10;
    localparam int unsigned NW = 1 << AW;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mcb_port_responder_if p0 ();

    mcb_port_responder #(
        .ADDR_WIDTH   (AW),
        .CMD_DEPTH    (4),
        .DATA_DEPTH   (64),
        .CALIB_CYCLES (16),
        .RD_LATENCY   (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .p0    (p0)
    );

    int total = 0;
    int bad = 0;
    int n_under = 0;
    int n_over = 0;
    logic [31:0] model [NW];
    logic [31:0] wd [64];
    logic [3:0]  wm [64];

    always @(negedge clk) begin
        if (p0.p0_wr_underrun) n_under++;
        if (p0.p0_rd_overflow) n_over++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_wr(input logic [3:0] m, input logic [31:0] d);
        p0.p0_wr_en   = 1'b1;
        p0.p0_wr_mask = m;
        p0.p0_wr_data = d;
        step(1);
        p0.p0_wr_en   = 1'b0;
    endtask

    task automatic push_cmd(input logic [2:0] ins, input logic [5:0] bl, input int unsigned word);
        int g = 0;
        while (p0.p0_cmd_full && g < 200) begin
            step(1);
            g++;
        end
        if (g == 200) chk("cmd_full_timeout", 32'(p0.p0_cmd_full), 32'd0);
        p0.p0_cmd_en        = 1'b1;
        p0.p0_cmd_instr     = ins;
        p0.p0_cmd_bl        = bl;
        p0.p0_cmd_byte_addr = 30'((word << 2) | $urandom_range(0, 3));
        step(1);
        p0.p0_cmd_en        = 1'b0;
    endtask

    // Writes beats from wd/wm; only the first n beats find data, the rest leave memory alone.
    task automatic wr_burst(input int unsigned word, input int bl, input int n, input bit push);
        if (push) for (int i = 0; i < n; i++) push_wr(wm[i], wd[i]);
        push_cmd(InstrWr, 6'(bl), word);
        for (int beat = 0; beat <= bl; beat++) begin
            if (beat < n) begin
                for (int b = 0; b < 4; b++) begin
                    if (!wm[beat][b]) model[(word + beat) % NW][8*b +: 8] = wd[beat][8*b +: 8];
                end
            end
        end
        step(bl + 6);
    endtask

    task automatic pop_check(input string tag, input int unsigned word, input int n);
        for (int i = 0; i < n; i++) begin
            int g = 0;
            while (p0.p0_rd_empty && g < 300) begin
                step(1);
                g++;
            end
            if (g == 300) chk({tag, "_timeout"}, 32'(p0.p0_rd_empty), 32'd0);
            chk(tag, p0.p0_rd_data, model[(word + i) % NW]);
            p0.p0_rd_en = 1'b1;
            step(1);
            p0.p0_rd_en = 1'b0;
        end
    endtask

    task automatic rd_burst(input string tag, input int unsigned word, input int bl);
        push_cmd(InstrRd, 6'(bl), word);
        pop_check(tag, word, bl + 1);
    endtask

    initial begin
        int base;
        int g;
        int unsigned w;
        int bl;
        p0.p0_cmd_en = 0; p0.p0_cmd_instr = 0; p0.p0_cmd_bl = 0; p0.p0_cmd_byte_addr = 0;
        p0.p0_wr_en = 0; p0.p0_wr_mask = 0; p0.p0_wr_data = 0; p0.p0_rd_en = 0;

        // Reset release and calibration window; fill the command FIFO meanwhile.
        step(3);
        reset = 1'b0;
        chk("rst_cmd_empty", 32'(p0.p0_cmd_empty), 32'd1);
        chk("rst_cmd_full", 32'(p0.p0_cmd_full), 32'd0);
        chk("rst_wr_empty", 32'(p0.p0_wr_empty), 32'd1);
        chk("rst_wr_count", 32'(p0.p0_wr_count), 32'd0);
        chk("rst_rd_empty", 32'(p0.p0_rd_empty), 32'd1);
        chk("rst_rd_full", 32'(p0.p0_rd_full), 32'd0);
        chk("rst_rd_count", 32'(p0.p0_rd_count), 32'd0);
        chk("rst_rd_data", p0.p0_rd_data, 32'd0);
        chk("rst_errors", 32'({p0.p0_wr_error, p0.p0_rd_error, p0.p0_wr_underrun,
                               p0.p0_rd_overflow}), 32'd0);
        for (int i = 0; i < 16; i++) begin
            p0.p0_cmd_en    = (i < 5);
            p0.p0_cmd_instr = (i < 4) ? 3'b100 : InstrWr;
            p0.p0_cmd_bl    = 6'd0;
            if (i == 4) chk("cmd_full_at_4", 32'(p0.p0_cmd_full), 32'd1);
            chk("calib_low", 32'(p0.calib_done), 32'd0);
            step(1);
        end
        p0.p0_cmd_en = 1'b0;
        chk("calib_high_16", 32'(p0.calib_done), 32'd1);
        step(10);
        chk("refresh_drained", 32'(p0.p0_cmd_empty), 32'd1);
        chk("full_cmd_ignored", 32'(p0.p0_wr_error), 32'd0);

        // Give every RAM word a known random value.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 64; i++) begin
                wd[i] = $urandom;
                wm[i] = 4'b0000;
            end
            wr_burst(k * 64, 63, 64, 1'b1);
        end

        // Four-word write then timed read-back.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h11111111 * (i + 1);
            wm[i] = 4'b0000;
        end
        wr_burst(32'h100 >> 2, 3, 4, 1'b1);
        push_cmd(InstrRd, 6'd3, 32'h100 >> 2);
        step(2);
        chk("rd_empty_t3", 32'(p0.p0_rd_empty), 32'd1);
        step(1);
        chk("rd_empty_t4", 32'(p0.p0_rd_empty), 32'd0);
        chk("rd_first_t4", p0.p0_rd_data, 32'h11111111);
        g = 0;
        while (p0.p0_rd_count != 4 && g < 20) begin
            step(1);
            g++;
        end
        chk("rd_count_peak", 32'(p0.p0_rd_count), 32'd4);
        pop_check("rd4", 32'h100 >> 2, 4);

        // Byte-masked write over zero.
        wd[0] = 32'h0; wm[0] = 4'b0000;
        wr_burst(32'h200, 0, 1, 1'b1);
        wd[0] = 32'hAABBCCDD; wm[0] = 4'b0101;
        wr_burst(32'h200, 0, 1, 1'b1);
        push_cmd(InstrRd, 6'd0, 32'h200);
        g = 0;
        while (p0.p0_rd_empty && g < 20) begin
            step(1);
            g++;
        end
        chk("mask_readback", p0.p0_rd_data, 32'hAA00CC00);
        p0.p0_rd_en = 1'b1; step(1); p0.p0_rd_en = 1'b0;

        // Underrun: eight beats, five words queued.
        for (int i = 0; i < 8; i++) begin
            wd[i] = $urandom;
            wm[i] = 4'(($urandom % 4 == 0) ? $urandom : 0);
        end
        base = n_under;
        wr_burst(32'h300, 7, 5, 1'b1);
        chk("underrun_pulses", 32'(n_under - base), 32'd3);
        chk("wr_error_underrun", 32'(p0.p0_wr_error), 32'd1);
        rd_burst("underrun_rd", 32'h300, 7);

        // Address wrap at the top of RAM.
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            wm[i] = 4'b0000;
        end
        wr_burst(NW - 2, 3, 4, 1'b1);
        rd_burst("wrap_rd", NW - 2, 3);
        rd_burst("wrap_low", 0, 1);

        // Random write/read pairs.
        for (int r = 0; r < 8; r++) begin
            w  = $urandom_range(0, NW - 1);
            bl = $urandom_range(0, 15);
            for (int i = 0; i <= bl; i++) begin
                wd[i] = $urandom;
                wm[i] = 4'($urandom);
            end
            wr_burst(w, bl, bl + 1, 1'b1);
            rd_burst("rand_rd", (w + $urandom_range(0, 3)) % NW, $urandom_range(0, 15));
        end

        // Two full reads with nobody popping.
        base = n_over;
        push_cmd(InstrRdAp, 6'd63, 0);
        push_cmd(InstrRd, 6'd63, 64);
        step(160);
        chk("ovf_rd_count", 32'(p0.p0_rd_count), 32'd64);
        chk("ovf_rd_full", 32'(p0.p0_rd_full), 32'd1);
        chk("ovf_pulses", 32'(n_over - base), 32'd64);
        chk("ovf_rd_error", 32'(p0.p0_rd_error), 32'd1);
        pop_check("ovf_drain", 0, 64);
        chk("ovf_drained", 32'(p0.p0_rd_empty), 32'd1);

        // Reset in the middle of a read burst.
        push_wr(4'h0, 32'hDEADBEEF);
        push_cmd(InstrRd, 6'd63, 0);
        step(10);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk("mid_rst_rd_empty", 32'(p0.p0_rd_empty), 32'd1);
        chk("mid_rst_rd_count", 32'(p0.p0_rd_count), 32'd0);
        chk("mid_rst_wr_empty", 32'(p0.p0_wr_empty), 32'd1);
        chk("mid_rst_errors", 32'({p0.p0_wr_error, p0.p0_rd_error}), 32'd0);
        chk("mid_rst_calib", 32'(p0.calib_done), 32'd0);
        step(3);
        chk("mid_rst_no_push", 32'(p0.p0_rd_empty), 32'd1);

        // Fill the write FIFO past full with no command queued.
        for (int i = 0; i < 64; i++) begin
            wd[i] = $urandom;
            wm[i] = 4'b0000;
            push_wr(wm[i], wd[i]);
        end
        push_wr(4'h0, 32'h0BAD0BAD);
        chk("wr_full", 32'(p0.p0_wr_full), 32'd1);
        chk("wr_count_full", 32'(p0.p0_wr_count), 32'd64);
        chk("wr_error_full", 32'(p0.p0_wr_error), 32'd1);
        wr_burst(32'h80, 63, 64, 1'b0);
        chk("wr_drained", 32'(p0.p0_wr_empty), 32'd1);
        rd_burst("full_rd", 32'h80, 63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
